// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone classic slave hosting a DEPTH x 32 FIFO mailbox behind DATA/STATUS/CTRL words.
// Latency: one wait state; ack_o or err_o pulses for exactly the cycle after the request edge.
// Backpressure: push when full / pop when empty terminate with err_o; irq_o exists only with WB_FIFO_SLAVE_IRQ_EN.
module wb_fifo_slave #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [3:0]            sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o
`ifdef WB_FIFO_SLAVE_IRQ_EN
    ,
    output logic                  irq_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_NONE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_ERR
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    ovf_q, ovf_d;
    logic                    udf_q, udf_d;
    logic                    irq_en_w;
    logic                    push;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    req;
    logic [1:0]              off;
    logic                    sel_ok;
    logic                    full;
    logic                    empty;
    logic [7:0]              cnt8;
    logic [31:0]             status_w;
    logic                    unused_adr;

    assign req    = cyc_i & stb_i & (state_q == S_IDLE);
    assign off    = adr_i[3:2];
    assign sel_ok = (sel_i == 4'hF);
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    // With DEPTH=256 the count field wraps to 0 when full; the full flag disambiguates.
    assign cnt8   = 8'(count_q);
    assign status_w = {8'h00, cnt8, 12'h000, udf_q, ovf_q, full, empty};
    assign unused_adr = ^{adr_i[ADDR_WIDTH-1:4], adr_i[1:0]};

`ifdef WB_FIFO_SLAVE_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_q;
    assign irq_en_w = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign irq_en_w = 1'b0;
`endif

    always_comb begin
        state_d  = S_IDLE;
        dat_d    = '0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        push     = 1'b0;
`ifdef WB_FIFO_SLAVE_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (req) begin
            unique case (off)
                OFF_DATA: begin
                    if (we_i) begin
                        if (!sel_ok) begin
                            state_d = S_ERR;
                        end else if (full) begin
                            state_d = S_ERR;
                            ovf_d   = 1'b1;
                        end else begin
                            state_d  = S_ACK;
                            push     = 1'b1;
                            wr_ptr_d = wr_ptr_q + 1'b1;
                            count_d  = count_q + 1'b1;
                        end
                    end else begin
                        if (empty) begin
                            state_d = S_ERR;
                            udf_d   = 1'b1;
                        end else begin
                            state_d  = S_ACK;
                            dat_d    = mem_q[rd_ptr_q];
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            count_d  = count_q - 1'b1;
                        end
                    end
                end
                OFF_STATUS: begin
                    if (we_i) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ACK;
                        dat_d   = DATA_WIDTH'(status_w);
                    end
                end
                OFF_CTRL: begin
                    if (we_i) begin
                        if (!sel_ok) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_ACK;
                            if (dat_i[0]) begin
                                wr_ptr_d = '0;
                                rd_ptr_d = '0;
                                count_d  = '0;
                                ovf_d    = 1'b0;
                                udf_d    = 1'b0;
                            end
`ifdef WB_FIFO_SLAVE_IRQ_EN
                            irq_en_d = dat_i[1];
`endif
                        end
                    end else begin
                        state_d = S_ACK;
                        dat_d   = DATA_WIDTH'({30'b0, irq_en_w, 1'b0});
                    end
                end
                OFF_NONE: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage carries no reset; contents are only observable through the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dat_i;
        end
    end

`ifdef WB_FIFO_SLAVE_IRQ_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_en_q & ~empty;
        end
    end
`endif

    assign ack_o = (state_q == S_ACK);
    assign err_o = (state_q == S_ERR);
    assign dat_o = dat_q;

endmodule

// File: tb/tb_wb_fifo_slave.sv
// Randomized bench for wb_fifo_slave against a queue-based mailbox model; build with WB_FIFO_SLAVE_IRQ_EN to cover irq_o.
module tb_wb_fifo_slave;

    localparam int DEPTH = 8;
`ifdef WB_FIFO_SLAVE_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [15:0] adr = '0;
    logic [31:0] dat_w = '0;
    logic [3:0]  sel = '0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;
`ifdef WB_FIFO_SLAVE_IRQ_EN
    logic        irq_o;
`endif

    wb_fifo_slave #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cyc_i (cyc),
        .stb_i (stb),
        .we_i  (we),
        .adr_i (adr),
        .dat_i (dat_w),
        .sel_i (sel),
        .dat_o (dat_o),
        .ack_o (ack_o),
        .err_o (err_o)
`ifdef WB_FIFO_SLAVE_IRQ_EN
        ,
        .irq_o (irq_o)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    bit          m_irq_en = 1'b0;

    bit          exp_ack = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_dat = '0;
    bit          exp_irq = 1'b0;

    logic [31:0] r_dat;
    logic        r_ack;
    logic        r_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_irq_en = 1'b0;
    endtask

    // Mailbox semantics straight from the register map.
    task automatic model_apply(input bit w, input logic [1:0] off, input logic [31:0] d,
                               input logic [3:0] s, output bit ea, output bit ee,
                               output logic [31:0] ed);
        ea = 1'b0;
        ee = 1'b0;
        ed = '0;
        case (off)
            2'd0: begin
                if (w) begin
                    if (s != 4'hF) ee = 1'b1;
                    else if (q.size() == DEPTH) begin ee = 1'b1; m_ovf = 1'b1; end
                    else begin q.push_back(d); ea = 1'b1; end
                end else begin
                    if (q.size() == 0) begin ee = 1'b1; m_udf = 1'b1; end
                    else begin ed = q.pop_front(); ea = 1'b1; end
                end
            end
            2'd1: begin
                if (w) ee = 1'b1;
                else begin
                    ea = 1'b1;
                    ed = {8'h00, 8'(q.size()), 12'h000, m_udf, m_ovf,
                          (q.size() == DEPTH), (q.size() == 0)};
                end
            end
            2'd2: begin
                if (w) begin
                    if (s != 4'hF) ee = 1'b1;
                    else begin
                        ea = 1'b1;
                        if (d[0]) begin q.delete(); m_ovf = 1'b0; m_udf = 1'b0; end
                        if (IRQ_EN) m_irq_en = d[1];
                    end
                end else begin
                    ea = 1'b1;
                    ed = {30'b0, m_irq_en, 1'b0};
                end
            end
            default: ee = 1'b1;
        endcase
    endtask

    // irq_o at edge M reflects the mailbox state left by edge M-1.
    always @(posedge clk or posedge rst) begin
        if (rst) exp_irq <= 1'b0;
        else     exp_irq <= m_irq_en && (q.size() != 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("ack_o", {31'b0, ack_o}, {31'b0, exp_ack});
            chk("err_o", {31'b0, err_o}, {31'b0, exp_err});
            chk("dat_o", dat_o, exp_dat);
`ifdef WB_FIFO_SLAVE_IRQ_EN
            chk("irq_o", {31'b0, irq_o}, {31'b0, exp_irq});
`endif
        end
    end

    task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold);
        bit ea, ee;
        logic [31:0] ed;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
        @(posedge clk); #1;
        model_apply(w, a[3:2], d, s, ea, ee, ed);
        exp_ack = ea; exp_err = ee; exp_dat = ed;
        r_dat = dat_o; r_ack = ack_o; r_err = err_o;
        if (!hold) begin cyc = 1'b0; stb = 1'b0; end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0;
    endtask

    task automatic rd_status(input string nm, input logic [31:0] exp);
        xfer(1'b0, 16'h0004, '0, 4'hF, 1'b0);
        chk(nm, r_dat, exp);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset ack", {31'b0, ack_o}, 32'd0);
        chk("reset err", {31'b0, err_o}, 32'd0);
        chk("reset dat", dat_o, 32'd0);
`ifdef WB_FIFO_SLAVE_IRQ_EN
        chk("reset irq", {31'b0, irq_o}, 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        rd_status("status after reset", 32'h0000_0001);
        chk("status ack", {31'b0, r_ack}, 32'd1);

        for (int i = 1; i <= 8; i++) begin
            xfer(1'b1, 16'h0000, 32'hA5A5_0000 + i, 4'hF, i[0]);
            chk("push ack", {31'b0, r_ack}, 32'd1);
        end
        rd_status("status full", 32'h0008_0002);
        xfer(1'b1, 16'h0000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        chk("ninth push err", {30'b0, r_ack, r_err}, 32'd1);
        rd_status("status ovf", 32'h0008_0006);

        for (int i = 1; i <= 8; i++) begin
            xfer(1'b0, 16'h0000, '0, 4'hF, 1'b0);
            chk("pop data", r_dat, 32'hA5A5_0000 + i);
        end
        xfer(1'b0, 16'h0000, '0, 4'hF, 1'b0);
        chk("ninth pop err", {30'b0, r_ack, r_err}, 32'd1);
        chk("ninth pop dat", r_dat, 32'd0);
        rd_status("status udf", 32'h0000_000D);

        xfer(1'b1, 16'h0008, 32'h1, 4'hF, 1'b0);
        rd_status("status flushed", 32'h0000_0001);
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 3; k++) xfer(1'b1, 16'h0000, 32'h1000 * r + k, 4'hF, 1'b0);
            for (int k = 0; k < 3; k++) begin
                xfer(1'b0, 16'h0000, '0, 4'hF, 1'b1);
                chk("wrap pop", r_dat, 32'h1000 * r + k);
            end
        end
        rd_status("status after wrap", 32'h0000_0001);

        xfer(1'b1, 16'h0000, 32'h0000_00AA, 4'hF, 1'b0);
        xfer(1'b0, 16'h000C, '0, 4'hF, 1'b0);
        chk("offset3 read err", {30'b0, r_ack, r_err}, 32'd1);
        xfer(1'b1, 16'h000C, 32'h1, 4'hF, 1'b0);
        chk("offset3 write err", {30'b0, r_ack, r_err}, 32'd1);
        xfer(1'b1, 16'h0004, 32'h1, 4'hF, 1'b0);
        chk("status write err", {30'b0, r_ack, r_err}, 32'd1);
        xfer(1'b1, 16'h0000, 32'h5555_5555, 4'h3, 1'b0);
        chk("partial sel err", {30'b0, r_ack, r_err}, 32'd1);
        xfer(1'b1, 16'h0008, 32'h1, 4'h7, 1'b0);
        chk("ctrl sel err", {30'b0, r_ack, r_err}, 32'd1);
        rd_status("status count unchanged", 32'h0001_0000);

        xfer(1'b1, 16'h0008, 32'h1, 4'hF, 1'b0);
        xfer(1'b1, 16'h0008, 32'h2, 4'hF, 1'b0);
        xfer(1'b0, 16'h0008, '0, 4'hF, 1'b0);
        chk("ctrl read", r_dat, IRQ_EN ? 32'h2 : 32'h0);
        xfer(1'b1, 16'h0000, 32'h0000_0077, 4'hF, 1'b0);
`ifdef WB_FIFO_SLAVE_IRQ_EN
        chk("irq after push", {31'b0, irq_o}, 32'd1);
`endif
        xfer(1'b0, 16'h0000, '0, 4'hF, 1'b0);
        chk("pop irq word", r_dat, 32'h0000_0077);
`ifdef WB_FIFO_SLAVE_IRQ_EN
        chk("irq after pop", {31'b0, irq_o}, 32'd0);
`endif
        xfer(1'b1, 16'h0000, 32'h0000_0088, 4'hF, 1'b0);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0004; sel = 4'hF;
        @(posedge clk); #1;
        chk("ack before reset", {31'b0, ack_o}, 32'd1);
        rst = 1'b1;
        model_reset();
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0;
        #1;
        chk("ack async reset", {31'b0, ack_o}, 32'd0);
        chk("dat async reset", dat_o, 32'd0);
`ifdef WB_FIFO_SLAVE_IRQ_EN
        chk("irq async reset", {31'b0, irq_o}, 32'd0);
`endif
        cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rd_status("status after mid reset", 32'h0000_0001);

        for (int n = 0; n < 600; n++) begin
            int unsigned pick;
            bit          w;
            logic [1:0]  off;
            logic [31:0] d;
            logic [3:0]  s;
            repeat ($urandom_range(0, 2)) begin
                stb = 1'($urandom_range(0, 1));
                cyc = 1'b0;
                @(posedge clk); #1;
            end
            stb = 1'b0;
            pick = $urandom_range(0, 15);
            d = $urandom;
            s = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'hF;
            if (pick < 10) begin
                off = 2'd0;
                w = ($urandom_range(0, 99) < 55);
            end else if (pick < 12) begin
                off = 2'd1;
                w = ($urandom_range(0, 5) == 0);
            end else if (pick < 14) begin
                off = 2'd2;
                w = 1'($urandom_range(0, 1));
                d[0] = ($urandom_range(0, 3) == 0);
            end else begin
                off = 2'd3;
                w = 1'($urandom_range(0, 1));
            end
            xfer(w, {12'($urandom), off, 2'($urandom)}, d, s, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
